// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU front end.
//   ALU_DATA_W / ALU_RESULT_W / ALU_MODE_W : operand, result and mode widths.
//   ENTRY_W                                : width of one queued {A, B, mode} triple.
//   seq_state_e                            : replay sequencer state encoding.
//   op_entry_t                             : packed layout of one queued operation.
package alu_pkg;

    localparam int unsigned ALU_DATA_W   = 5;
    localparam int unsigned ALU_RESULT_W = 10;
    localparam int unsigned ALU_MODE_W   = 2;
    localparam int unsigned ENTRY_W      = ALU_DATA_W * 2 + ALU_MODE_W;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StDwell  = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
        logic [ALU_MODE_W-1:0] mode;
    } op_entry_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: bundles the switch/button inputs, the ALU core connection and the
// display-side outputs of the sequencer.
//   slave  : the sequencer's view (inputs from board and ALU, outputs to ALU and display).
//   master : the environment's view (board controls, ALU core, display path).
interface alu_op_sequencer_if #(
    parameter int unsigned DEPTH = 4
) ();
    import alu_pkg::*;

    localparam int unsigned CountW = $clog2(DEPTH) + 1;

    logic                    tick;
    logic                    enter;
    logic                    run;
    logic [ALU_DATA_W-1:0]   A_in;
    logic [ALU_DATA_W-1:0]   B_in;
    logic [ALU_MODE_W-1:0]   mode_in;
    logic [ALU_RESULT_W-1:0] alu_out;
    logic                    alu_negative;
    logic [ALU_DATA_W-1:0]   alu_A;
    logic [ALU_DATA_W-1:0]   alu_B;
    logic [ALU_MODE_W-1:0]   alu_mode;
    logic [ALU_RESULT_W-1:0] result;
    logic                    result_negative;
    logic                    result_valid;
    logic                    busy;
    logic                    done;
    logic [CountW-1:0]       count;
    logic                    full;
    logic                    empty;
    logic                    overflow;

    modport slave (
        input  tick, enter, run, A_in, B_in, mode_in, alu_out, alu_negative,
        output alu_A, alu_B, alu_mode, result, result_negative, result_valid,
               busy, done, count, full, empty, overflow
    );

    modport master (
        output tick, enter, run, A_in, B_in, mode_in, alu_out, alu_negative,
        input  alu_A, alu_B, alu_mode, result, result_negative, result_valid,
               busy, done, count, full, empty, overflow
    );

endinterface

// File: rtl/alu_op_sequencer_op_fifo.sv
// op_fifo: synchronous FIFO holding queued ALU operations.
//   clock_100Mhz, reset : clock and synchronous active-high reset.
//   push / din          : write request and data; a push while full is taken only together
//                         with a pop on the same edge.
//   pop                 : advance past the head; ignored when empty.
//   dout                : current head, visible without popping.
//   count, full, empty  : occupancy after the preceding edge.
module op_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12
) (
    input  logic                     clock_100Mhz,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CountW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop on the same edge frees the slot this push needs.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CountW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CountW'(1);
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only read while count is non-zero.
    always_ff @(posedge clock_100Mhz) begin
        if (push_ok && !reset) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues {A, B, mode} triples from the switches and, on run, replays them
// through the shared ALU: drive operands, wait SETTLE_CYCLES, capture the result, hold it for
// DWELL_TICKS display ticks, then issue the next queued entry.
//   clock_100Mhz, reset : clock and synchronous active-high reset.
//   bus (slave)         : tick/enter/run and switch inputs, ALU result in, registered ALU
//                         operands out, captured result and queue status out.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DWELL_TICKS   = 750
) (
    input  logic              clock_100Mhz,
    input  logic              reset,
    alu_op_sequencer_if.slave bus
);
    localparam int unsigned CountW  = $clog2(DEPTH) + 1;
    localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned DwellW  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    // Counters run down to zero, so loading N-1 gives exactly N cycles / ticks.
    localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_CYCLES - 1);
    localparam logic [DwellW-1:0]  DwellLoad  = DwellW'(DWELL_TICKS - 1);

    seq_state_e              state_q, state_d;
    logic [SettleW-1:0]      settle_cnt_q, settle_cnt_d;
    logic [DwellW-1:0]       dwell_cnt_q, dwell_cnt_d;
    op_entry_t               alu_op_q, alu_op_d;
    logic [ALU_RESULT_W-1:0] result_q, result_d;
    logic                    result_negative_q, result_negative_d;
    logic                    result_valid_q, result_valid_d;
    logic                    done_q, done_d;
    logic                    overflow_q, overflow_d;

    op_entry_t         fifo_din, fifo_dout;
    logic              fifo_pop;
    logic [CountW-1:0] fifo_count;
    logic              fifo_full, fifo_empty;
    logic              settle_end, dwell_end;

    assign fifo_din   = {bus.A_in, bus.B_in, bus.mode_in};
    assign settle_end = (state_q == StSettle) && (settle_cnt_q == '0);
    assign dwell_end  = (state_q == StDwell) && bus.tick && (dwell_cnt_q == '0);

    op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_op_fifo (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .push         (bus.enter),
        .pop          (fifo_pop),
        .din          (fifo_din),
        .dout         (fifo_dout),
        .count        (fifo_count),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

    // State register.
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.run && !fifo_empty) state_d = StSettle;
            StSettle: if (settle_end) state_d = StDwell;
            StDwell:  if (dwell_end) state_d = fifo_empty ? StIdle : StSettle;
            default:  state_d = StIdle;
        endcase
    end

    // Per-state actions: queue pops, counters, capture and pulses.
    always_comb begin
        fifo_pop          = 1'b0;
        settle_cnt_d      = settle_cnt_q;
        dwell_cnt_d       = dwell_cnt_q;
        alu_op_d          = alu_op_q;
        result_d          = result_q;
        result_negative_d = result_negative_q;
        result_valid_d    = result_valid_q;
        done_d            = 1'b0;
        unique case (state_q)
            StIdle: begin
                fifo_pop = bus.run && !fifo_empty;
            end
            StSettle: begin
                if (settle_end) begin
                    result_d          = bus.alu_out;
                    result_negative_d = bus.alu_negative;
                    result_valid_d    = 1'b1;
                    dwell_cnt_d       = DwellLoad;
                end else begin
                    settle_cnt_d = settle_cnt_q - SettleW'(1);
                end
            end
            StDwell: begin
                if (dwell_end) begin
                    fifo_pop = !fifo_empty;
                    done_d   = fifo_empty;
                end else if (bus.tick) begin
                    dwell_cnt_d = dwell_cnt_q - DwellW'(1);
                end
            end
            default: ;
        endcase
        if (fifo_pop) begin
            alu_op_d     = fifo_dout;
            settle_cnt_d = SettleLoad;
        end
        // fifo_pop implies non-empty, so a pop always makes room for this enter.
        overflow_d = bus.enter && fifo_full && !fifo_pop;
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            settle_cnt_q      <= '0;
            dwell_cnt_q       <= '0;
            alu_op_q          <= '0;
            result_q          <= '0;
            result_negative_q <= 1'b0;
            result_valid_q    <= 1'b0;
            done_q            <= 1'b0;
            overflow_q        <= 1'b0;
        end else begin
            settle_cnt_q      <= settle_cnt_d;
            dwell_cnt_q       <= dwell_cnt_d;
            alu_op_q          <= alu_op_d;
            result_q          <= result_d;
            result_negative_q <= result_negative_d;
            result_valid_q    <= result_valid_d;
            done_q            <= done_d;
            overflow_q        <= overflow_d;
        end
    end

    assign bus.alu_A           = alu_op_q.a;
    assign bus.alu_B           = alu_op_q.b;
    assign bus.alu_mode        = alu_op_q.mode;
    assign bus.result          = result_q;
    assign bus.result_negative = result_negative_q;
    assign bus.result_valid    = result_valid_q;
    assign bus.busy            = (state_q != StIdle);
    assign bus.done            = done_q;
    assign bus.count           = fifo_count;
    assign bus.full            = fifo_full;
    assign bus.empty           = fifo_empty;
    assign bus.overflow        = overflow_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a transaction-level reference model predicts every output
// after each clock edge into a scoreboard queue; an independent monitor pops and compares.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 4;
    localparam int DWELL  = 3;
    localparam int TICK_P = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_pos = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_op_sequencer_if #(.DEPTH(DEPTH)) bus ();

    alu_op_sequencer #(
        .DEPTH         (DEPTH),
        .SETTLE_CYCLES (SETTLE),
        .DWELL_TICKS   (DWELL)
    ) dut (
        .clock_100Mhz (clk),
        .reset        (reset),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        n_pos <= n_pos + 1;
    end

    assign bus.tick = (cyc % TICK_P == TICK_P - 1);

    // Stand-in ALU core: {negative, result}.
    function automatic logic [10:0] alu_f(input logic [4:0] a, input logic [4:0] b,
                                          input logic [1:0] m);
        case (m)
            2'd0:    return {1'b0, 10'(a) + 10'(b)};
            2'd1:    return (a < b) ? {1'b1, 10'(b - a)} : {1'b0, 10'(a - b)};
            2'd2:    return {1'b0, 10'(a) * 10'(b)};
            default: return {1'b0, 5'd0, a ^ b};
        endcase
    endfunction

    assign {bus.alu_negative, bus.alu_out} = alu_f(bus.alu_A, bus.alu_B, bus.alu_mode);

    typedef struct {
        int         edge_no;
        logic [4:0] a, b;
        logic [1:0] mode;
        logic [9:0] res;
        logic       neg, rv, busy, done, ovf, full, empty;
        logic [2:0] count;
    } snap_t;

    snap_t      exp_q[$];
    op_entry_t  mq[$];
    op_entry_t  m_cur = '0;
    logic [9:0] m_res = '0;
    logic       m_neg = 1'b0;
    logic       m_rv = 1'b0;
    bit         m_act = 1'b0;
    bit         m_settling = 1'b0;
    int         m_ticks = 0;
    int         m_cap_edge = 0;

    // Reference model: on each falling edge, apply the inputs now present to predict the
    // outputs after the next rising edge.
    always @(negedge clk) begin : model
        snap_t       s;
        logic [10:0] r;
        bit          pop, ovf, dn;
        int          sz, nxt;
        nxt = n_pos + 1;
        pop = 1'b0;
        ovf = 1'b0;
        dn  = 1'b0;
        if (reset) begin
            mq.delete();
            m_cur = '0; m_res = '0; m_neg = 1'b0; m_rv = 1'b0;
            m_act = 1'b0; m_settling = 1'b0; m_ticks = 0;
        end else begin
            sz = mq.size();
            if (!m_act) begin
                pop = bus.run && (sz > 0);
            end else if (m_settling) begin
                if (nxt == m_cap_edge) begin
                    r = alu_f(m_cur.a, m_cur.b, m_cur.mode);
                    m_res = r[9:0];
                    m_neg = r[10];
                    m_rv = 1'b1;
                    m_settling = 1'b0;
                    m_ticks = 0;
                end
            end else if (bus.tick) begin
                m_ticks++;
                if (m_ticks == DWELL) begin
                    if (sz > 0) pop = 1'b1;
                    else begin
                        dn = 1'b1;
                        m_act = 1'b0;
                    end
                end
            end
            ovf = bus.enter && (sz == DEPTH) && !pop;
            if (pop) begin
                m_cur = mq.pop_front();
                m_act = 1'b1;
                m_settling = 1'b1;
                m_cap_edge = nxt + SETTLE;
            end
            if (bus.enter && !ovf) mq.push_back({bus.A_in, bus.B_in, bus.mode_in});
        end
        s.edge_no = nxt;
        s.a = m_cur.a; s.b = m_cur.b; s.mode = m_cur.mode;
        s.res = m_res; s.neg = m_neg; s.rv = m_rv;
        s.busy = m_act; s.done = dn; s.ovf = ovf;
        s.count = 3'(mq.size());
        s.full = (mq.size() == DEPTH);
        s.empty = (mq.size() == 0);
        exp_q.push_back(s);
    end

    task automatic check(input string name, input int e, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s after edge %0d: got %0h, expected %0h", name, e, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        snap_t e;
        while (exp_q.size() > 0 && exp_q[0].edge_no <= n_pos) begin
            e = exp_q.pop_front();
            check("alu_A", e.edge_no, 32'(bus.alu_A), 32'(e.a));
            check("alu_B", e.edge_no, 32'(bus.alu_B), 32'(e.b));
            check("alu_mode", e.edge_no, 32'(bus.alu_mode), 32'(e.mode));
            check("result", e.edge_no, 32'(bus.result), 32'(e.res));
            check("result_negative", e.edge_no, 32'(bus.result_negative), 32'(e.neg));
            check("result_valid", e.edge_no, 32'(bus.result_valid), 32'(e.rv));
            check("busy", e.edge_no, 32'(bus.busy), 32'(e.busy));
            check("done", e.edge_no, 32'(bus.done), 32'(e.done));
            check("overflow", e.edge_no, 32'(bus.overflow), 32'(e.ovf));
            check("count", e.edge_no, 32'(bus.count), 32'(e.count));
            check("full", e.edge_no, 32'(bus.full), 32'(e.full));
            check("empty", e.edge_no, 32'(bus.empty), 32'(e.empty));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_enter(input logic [4:0] a, input logic [4:0] b, input logic [1:0] m);
        bus.A_in = a; bus.B_in = b; bus.mode_in = m;
        bus.enter = 1'b1;
        step(1);
        bus.enter = 1'b0;
    endtask

    task automatic pulse_run();
        bus.run = 1'b1;
        step(1);
        bus.run = 1'b0;
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired, got no progress, expected completion", name);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (!m_act) break;
            step(1);
        end
        if (i == 3000) timeout_fail("wait_idle");
    endtask

    task automatic wait_dwell();
        int i;
        for (i = 0; i < 200; i++) begin
            if (m_act && !m_settling) break;
            step(1);
        end
        if (i == 200) timeout_fail("wait_dwell");
    endtask

    initial begin
        bus.enter = 1'b0; bus.run = 1'b0;
        bus.A_in = '0; bus.B_in = '0; bus.mode_in = '0;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(3);
        // Run with an empty queue is ignored.
        pulse_run();
        step(5);

        // Single operation.
        do_enter(5'd5, 5'd3, 2'd0);
        pulse_run();
        wait_idle();
        step(2);

        // Five enters into a 4-deep queue, then replay.
        for (int i = 0; i < 5; i++) do_enter(5'($urandom), 5'($urandom), 2'($urandom));
        step(2);
        pulse_run();
        wait_idle();
        step(2);

        // Enter during the dwell of a one-entry run joins the same run.
        do_enter(5'd7, 5'd9, 2'd1);
        pulse_run();
        wait_dwell();
        do_enter(5'd31, 5'd31, 2'd3);
        wait_idle();
        step(2);

        // Full queue with an enter on the dwell-ending edge.
        do_enter(5'd2, 5'd30, 2'd1);
        pulse_run();
        for (int i = 0; i < 4; i++) do_enter(5'($urandom), 5'($urandom), 2'($urandom));
        begin
            int k;
            for (k = 0; k < 200; k++) begin
                if (m_act && !m_settling && m_ticks == DWELL - 1 && bus.tick) break;
                step(1);
            end
            if (k == 200) timeout_fail("wait_dwell_end");
            bus.A_in = 5'd17; bus.B_in = 5'd4; bus.mode_in = 2'd2;
            bus.enter = 1'b1;
            step(1);
            bus.enter = 1'b0;
        end
        wait_idle();
        step(2);

        // Randomised traffic, including occasional resets.
        for (int i = 0; i < 600; i++) begin
            bus.enter = ($urandom_range(0, 4) == 0);
            bus.run = ($urandom_range(0, 15) == 0);
            bus.A_in = 5'($urandom);
            bus.B_in = 5'($urandom);
            bus.mode_in = 2'($urandom);
            reset = ($urandom_range(0, 249) == 0);
            step(1);
        end
        bus.enter = 1'b0; bus.run = 1'b0; reset = 1'b0;
        step(1);
        pulse_run();
        wait_idle();
        step(2);

        // Reset in the middle of SETTLE, then run on the emptied queue.
        do_enter(5'd3, 5'd4, 2'd2);
        do_enter(5'd6, 5'd1, 2'd1);
        pulse_run();
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        pulse_run();
        step(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Queues up to DEPTH operand/mode triples entered from the board switches and, on a run command, replays them one at a time through the shared ALU core. For each queued operation it:
- drives the ALU operands and mode,
- waits a fixed settle time,
- captures the result,
- holds that result for the display path for a fixed number of display ticks before issuing the next one.

It sits between the switch/button inputs and alu_core. Its captured result feeds BCD_convert and cathode_driver in place of the raw ALU output.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- SETTLE_CYCLES, 4: clock_100Mhz cycles between ALU operand update and result capture; at least 1.
- DWELL_TICKS, 750: tick pulses for which each captured result is held (1 s at 750 Hz); at least 1.

Ports:
- clock_100Mhz  in  1  system clock; the block's only clock.
- reset  in  1  synchronous, active-high; clears all state.
- tick  in  1  one-cycle strobe per slow display clock period.
- enter  in  1  one-cycle, debounced pulse; pushes {A_in, B_in, mode_in}.
- run  in  1  one-cycle, debounced pulse; starts replay.
- A_in  in  5  operand A from switches.
- B_in  in  5  operand B from switches.
- mode_in  in  2  ALU mode; passed through opaquely.
- alu_out  in  10  ALU result.
- alu_negative  in  1  ALU sign flag.
- alu_A  out  5  operand A to ALU; registered.
- alu_B  out  5  operand B to ALU; registered.
- alu_mode  out  2  mode to ALU; registered.
- result  out  10  captured result for BCD conversion.
- result_negative  out  1  captured sign.
- result_valid  out  1  high once any result has been captured.
- busy  out  1  high in SETTLE or DWELL.
- done  out  1  one-cycle pulse when the last queued operation's dwell ends.
- count  out  $clog2(DEPTH)+1  number of queued entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  one-cycle pulse when an enter is dropped.

## Operation
- States: IDLE, SETTLE, DWELL.
- IDLE:
  - run with !empty: pop the head into alu_A/alu_B/alu_mode on that edge, load the settle counter, go to SETTLE.
  - run with empty: ignored; no state change, no pulse.
- SETTLE: lasts exactly SETTLE_CYCLES cycles. On its final edge: result <= alu_out, result_negative <= alu_negative, result_valid <= 1, load the dwell counter, go to DWELL.
- DWELL:
  - The dwell counter decrements on each cycle with tick=1. Cycles without tick do not count.
  - On the edge sampling the DWELL_TICKS-th tick:
    - if !empty: pop the next entry into alu_*, go to SETTLE;
    - else: pulse done, go to IDLE.
- run while busy: ignored.
- enter:
  - Accepted in any state; queue order is FIFO.
  - Entries pushed during replay are executed in the same run.
  - When full and no pop occurs that cycle: entry dropped, overflow pulses, queue unchanged.
  - When full with a pop in the same cycle: push accepted, count unchanged.
- alu_* hold their last values in IDLE, so the ALU keeps evaluating the last operation.
- result and result_valid hold until the next capture or reset.
- tick arriving in IDLE or SETTLE: no effect.

## Timing
- Reset values: all outputs 0 except empty=1. State = IDLE, queue emptied, both counters 0.
- Reset asserted mid-SETTLE or mid-DWELL aborts immediately. The next cycle shows reset values; done does not pulse.
- run sampled at edge N:
  - alu_* are valid after edge N;
  - result is captured at edge N+SETTLE_CYCLES;
  - busy rises after edge N.
- count, full and empty reflect push/pop from the preceding edge.
- overflow and done are exactly one cycle wide.

## Structure
- Shared package alu_pkg holds:
  - constants: ALU_DATA_W=5, ALU_RESULT_W=10, ALU_MODE_W=2;
  - the sequencer state encoding (IDLE/SETTLE/DWELL);
  - the queue entry width, ALU_DATA_W*2+ALU_MODE_W = 12.
- Sub-module op_fifo: synchronous FIFO, parameters DEPTH and WIDTH=12.
  - Ports: push, pop, din, dout (head, visible without pop), count, full, empty.
  - Push while full is accepted only with a simultaneous pop.
- Sequencer FSM and both counters live in alu_op_sequencer.

## Test plan
Bench settings: SETTLE_CYCLES=4, DWELL_TICKS=3, tick every 10 cycles.
- Reset then idle: all outputs 0, empty=1. run with an empty queue leaves busy=0 and done=0.
- Single operation: push A=5, B=3, mode=0, then run.
  - alu_A=5 and alu_B=3 one cycle after run.
  - result equals the model alu_out exactly 4 cycles after run.
  - result_valid=1; done pulses after the 3rd tick; count returns to 0.
- Queue of 4 with a 5th enter:
  - overflow pulses on the 5th enter; count stays 4, full=1.
  - run replays the 4 entries in entry order, each held for 3 ticks, then one done pulse.
- Enter during DWELL of a 1-entry run: the new entry (A=31, B=31, mode=3) executes next in the same run; done pulses only after the second dwell.
- Full queue with a pop and an enter on the same edge at dwell end: push accepted, no overflow, count stays 4.
- Reset asserted mid-SETTLE: busy=0, count=0 and result_valid=0 the next cycle; no done pulse; a subsequent run with an empty queue is ignored.
